// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC types and constants.
//   FLIT_DATA_SIZE : FIFO word width between DLA engines and the router bridge.
//   HEAD_LEN_LSB/W : position of the 8-bit body-length field in a head word.
//   arb_state_t    : states of the source packet arbiter.
package noc_pkg;
  localparam int FLIT_DATA_SIZE = 32;
  localparam int HEAD_LEN_W     = 8;
  localparam int HEAD_LEN_LSB   = FLIT_DATA_SIZE - 19;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HEAD_CAP,
    BODY,
    RELEASE
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        : per-requester request bits.
//   rr_ptr     : last served index; the search starts at rr_ptr+1 and wraps.
//   gnt_onehot : one-hot grant, all zero when nothing requests.
//   gnt_idx    : binary index of the grant, 0 when nothing requests.
module rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [N_SRC-1:0] gnt_onehot,
  output logic [SRC_W-1:0] gnt_idx
);
  logic [SRC_W-1:0] cand;
  logic             found;

  // Linear scan in priority order; the modulo keeps non-power-of-two
  // N_SRC from ever producing an out-of-range candidate.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % N_SRC);
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end
endmodule

// File: rtl/noc_src_packet_arbiter.sv
// noc_src_packet_arbiter: shares one virtual FIFO read port among N_SRC
// source FIFOs, packet-granular round-robin.
//   clk_router, rst_router : clock, async active-high reset.
//   src_rempty/src_ren/src_rdata : per-source FIFO side (data valid the cycle
//                                  after ren).
//   dst_rempty/dst_ren/dst_rdata : virtual FIFO presented to the bridge.
//   grant_valid/grant_id   : current owner of the port.
//   pkt_done               : one-cycle pulse as ownership is released.
module noc_src_packet_arbiter
  import noc_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = FLIT_DATA_SIZE,
  parameter int SRC_W  = $clog2(N_SRC)
) (
  input  logic                    clk_router,
  input  logic                    rst_router,
  input  logic [N_SRC-1:0]        src_rempty,
  output logic [N_SRC-1:0]        src_ren,
  input  logic [N_SRC*DATA_W-1:0] src_rdata,
  output logic                    dst_rempty,
  input  logic                    dst_ren,
  output logic [DATA_W-1:0]       dst_rdata,
  output logic                    grant_valid,
  output logic [SRC_W-1:0]        grant_id,
  output logic                    pkt_done
);
  arb_state_t                  state, state_nxt;
  logic                        grant_valid_nxt;
  logic [SRC_W-1:0]            grant_id_nxt;
  logic [SRC_W-1:0]            rr_ptr, rr_ptr_nxt;
  logic [HEAD_LEN_W-1:0]       remaining, remaining_nxt;
  logic [N_SRC-1:0][DATA_W-1:0] src_words;
  logic [N_SRC-1:0]            arb_onehot;
  logic [SRC_W-1:0]            arb_idx;
  logic                        arb_any;
  logic                        cur_empty;
  logic                        pop;

  assign src_words = src_rdata;
  assign arb_any   = |arb_onehot;
  assign cur_empty = src_rempty[grant_id];
  assign dst_rdata = grant_valid ? src_words[grant_id] : '0;

  rr_arbiter #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_rr (
    .req        (~src_rempty),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  // The port only looks non-empty while a word of the owned packet may
  // legally be read; HEAD_CAP and RELEASE block reads so the length can be
  // captured and the last word presented before the next packet.
  always_comb begin
    dst_rempty = 1'b1;
    case (state)
      ARMED:   dst_rempty = cur_empty;
      BODY:    dst_rempty = cur_empty | (remaining == '0);
      default: dst_rempty = 1'b1;
    endcase
  end

  assign pop = dst_ren & ~dst_rempty;

  always_comb begin
    src_ren = '0;
    if (pop) src_ren[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt       = state;
    grant_valid_nxt = grant_valid;
    grant_id_nxt    = grant_id;
    rr_ptr_nxt      = rr_ptr;
    remaining_nxt   = remaining;
    pkt_done        = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_id_nxt    = arb_idx;
          grant_valid_nxt = 1'b1;
          state_nxt       = ARMED;
        end
      end
      ARMED: begin
        if (pop) state_nxt = HEAD_CAP;
      end
      HEAD_CAP: begin
        // Head word popped last cycle is on dst_rdata now.
        remaining_nxt = dst_rdata[DATA_W-12 -: HEAD_LEN_W];
        state_nxt     = (remaining_nxt == '0) ? RELEASE : BODY;
      end
      BODY: begin
        if (pop) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == HEAD_LEN_W'(1)) state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        pkt_done        = 1'b1;
        rr_ptr_nxt      = grant_id;
        grant_valid_nxt = 1'b0;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_router or posedge rst_router) begin
    if (rst_router) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= SRC_W'(N_SRC - 1);
      remaining   <= '0;
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      rr_ptr      <= rr_ptr_nxt;
      remaining   <= remaining_nxt;
    end
  end
endmodule

// File: tb/tb_noc_src_packet_arbiter.sv
// Bench: source FIFOs modelled as queues, a packet-level reference model
// that tracks ownership by counting the pops a packet still needs, directed
// scenarios with literal expectations, then randomized traffic.
module tb_noc_src_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk_router = 1'b0;
  logic            rst_router = 1'b1;
  logic [N-1:0]    src_rempty;
  logic [N-1:0]    src_ren;
  logic [N*DW-1:0] src_rdata;
  logic            dst_rempty;
  logic            dst_ren;
  logic [DW-1:0]   dst_rdata;
  logic            grant_valid;
  logic [SW-1:0]   grant_id;
  logic            pkt_done;

  always #5 clk_router = ~clk_router;

  noc_src_packet_arbiter #(.N_SRC(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk_router  (clk_router),
    .rst_router  (rst_router),
    .src_rempty  (src_rempty),
    .src_ren     (src_ren),
    .src_rdata   (src_rdata),
    .dst_rempty  (dst_rempty),
    .dst_ren     (dst_ren),
    .dst_rdata   (dst_rdata),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .pkt_done    (pkt_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // environment: source FIFOs
  logic [DW-1:0] fq [N][$];
  logic [DW-1:0] fout [N];
  logic [N-1:0]  hold;
  int            words_pushed;

  // reference model
  logic [DW-1:0] mq [N][$];
  int            lq [N][$];
  logic [DW-1:0] m_out [N];
  int            m_owner, m_gid, m_rr, m_left, m_npop;
  bit            m_hold, m_rel;
  logic [N-1:0]  m_pop;

  // scoreboard for directed scenarios
  int            pops [N];
  int            grants[$];
  int            done_cyc[$];
  int            pop_cyc[$];
  logic [DW-1:0] obs[$];
  bit            data_pend, prev_gv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] head_word(input int s, input int len);
    return (DW'(s) << 28) | (DW'(len) << 13) | DW'(1);
  endfunction

  function automatic logic [DW-1:0] body_word(input int s, input int i);
    return (DW'(s) << 28) | (DW'(i) << 24) | DW'(i * 3 + 1);
  endfunction

  task automatic push_pkt(input int s, input int len);
    logic [DW-1:0] w;
    w = head_word(s, len);
    fq[s].push_back(w); mq[s].push_back(w);
    for (int i = 1; i <= len; i++) begin
      w = body_word(s, i);
      fq[s].push_back(w); mq[s].push_back(w);
    end
    lq[s].push_back(len);
    words_pushed += 1 + len;
  endtask

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_rr = N - 1; m_left = 0; m_npop = 0;
    m_hold = 0; m_rel = 0; m_pop = '0;
  endtask

  task automatic sb_clear();
    for (int i = 0; i < N; i++) pops[i] = 0;
    grants.delete(); done_cyc.delete(); pop_cyc.delete(); obs.delete();
    data_pend = 0; prev_gv = 0;
  endtask

  // Expected outputs from model state and this cycle's inputs.
  task automatic compare();
    bit            e_gv, e_rempty;
    logic [DW-1:0] e_rdata;
    e_gv     = (m_owner >= 0);
    e_rempty = 1'b1;
    if (e_gv && !m_hold && !m_rel && m_left > 0 && !src_rempty[m_owner]) e_rempty = 1'b0;
    m_pop = '0;
    if (dst_ren && !e_rempty) m_pop[m_owner] = 1'b1;
    e_rdata = e_gv ? m_out[m_owner] : '0;
    chk("grant_valid", 64'(grant_valid), 64'(e_gv));
    chk("grant_id",    64'(grant_id),    64'(m_gid));
    chk("dst_rempty",  64'(dst_rempty),  64'(e_rempty));
    chk("src_ren",     64'(src_ren),     64'(m_pop));
    chk("pkt_done",    64'(pkt_done),    64'(m_rel));
    chk("dst_rdata",   64'(dst_rdata),   64'(e_rdata));
  endtask

  task automatic model_update();
    int l;
    if (rst_router) begin model_reset(); return; end
    if (m_rel) begin
      m_rr = m_owner; m_owner = -1; m_rel = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_rr + k) % N;
        if (!src_rempty[s]) begin
          m_owner = s; m_gid = s; m_npop = 0;
          chk("model_pkt_queued", 64'(lq[s].size() > 0), 64'd1);
          l = 0;
          if (lq[s].size() > 0) l = lq[s].pop_front();
          m_left = 1 + l;
          break;
        end
      end
    end else if (m_hold) begin
      m_hold = 0;
      if (m_left == 0) m_rel = 1;
    end else if (|m_pop) begin
      if (mq[m_owner].size() > 0) m_out[m_owner] = mq[m_owner].pop_front();
      m_left--; m_npop++;
      if (m_npop == 1) m_hold = 1;
      else if (m_left == 0) m_rel = 1;
    end
  endtask

  // One clock: drive inputs and compare at the falling edge, update the
  // FIFOs and the model just after the rising edge.
  task automatic step(input bit ren);
    logic [N-1:0] ren_s;
    @(negedge clk_router);
    dst_ren = ren;
    for (int i = 0; i < N; i++) src_rempty[i] = (fq[i].size() == 0) || hold[i];
    #1;
    compare();
    if (data_pend) obs.push_back(dst_rdata);
    data_pend = |src_ren;
    if (pkt_done) done_cyc.push_back(cyc);
    if (grant_valid && !prev_gv) grants.push_back(int'(grant_id));
    prev_gv = grant_valid;
    for (int i = 0; i < N; i++) if (src_ren[i]) begin pops[i]++; pop_cyc.push_back(cyc); end
    ren_s = src_ren;
    @(posedge clk_router);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ren_s[i] && fq[i].size() > 0) fout[i] = fq[i].pop_front();
      src_rdata[i*DW +: DW] = fout[i];
    end
    model_update();
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_router);
    rst_router = 1'b1;
    dst_ren    = 1'b1;
    #1;
    chk("rst_src_ren",     64'(src_ren),     64'd0);
    chk("rst_dst_rempty",  64'(dst_rempty),  64'd1);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_id",    64'(grant_id),    64'd0);
    chk("rst_pkt_done",    64'(pkt_done),    64'd0);
    chk("rst_dst_rdata",   64'(dst_rdata),   64'd0);
    for (int i = 0; i < N; i++) begin fq[i].delete(); mq[i].delete(); lq[i].delete(); end
    hold = '0;
    model_reset();
    repeat (2) step(1'b0);
    rst_router = 1'b0;
    sb_clear();
  endtask

  initial begin
    int b, tp, d0, d3;
    dst_ren = 1'b0; src_rempty = '1; src_rdata = '0; hold = '0; words_pushed = 0;
    for (int i = 0; i < N; i++) begin fout[i] = '0; m_out[i] = '0; end
    model_reset();
    sb_clear();
    do_reset();

    // single source, len 3
    push_pkt(0, 3);
    repeat (10) step(1'b1);
    chk("t1_pops0", 64'(pops[0]), 64'd4);
    chk("t1_nobs", 64'(obs.size()), 64'd4);
    if (obs.size() == 4) begin
      chk("t1_w0", 64'(obs[0]), 64'h0000_6001);
      chk("t1_w1", 64'(obs[1]), 64'h0100_0004);
      chk("t1_w2", 64'(obs[2]), 64'h0200_0007);
      chk("t1_w3", 64'(obs[3]), 64'h0300_000A);
    end
    chk("t1_ndone", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() == 1 && pop_cyc.size() == 4)
      chk("t1_done_lat", 64'(done_cyc[0] - pop_cyc[3]), 64'd1);
    chk("t1_gv_end", 64'(grant_valid), 64'd0);

    // three sources contend from reset
    do_reset();
    push_pkt(0, 2); push_pkt(1, 2); push_pkt(2, 2);
    repeat (22) step(1'b1);
    chk("t2_ngrants", 64'(grants.size()), 64'd3);
    if (grants.size() == 3) begin
      chk("t2_g0", 64'(grants[0]), 64'd0);
      chk("t2_g1", 64'(grants[1]), 64'd1);
      chk("t2_g2", 64'(grants[2]), 64'd2);
    end
    chk("t2_ndone", 64'(done_cyc.size()), 64'd3);
    if (done_cyc.size() == 3) begin
      chk("t2_gap01", 64'(done_cyc[1] - done_cyc[0]), 64'd6);
      chk("t2_gap12", 64'(done_cyc[2] - done_cyc[1]), 64'd6);
    end
    chk("t2_pops1", 64'(pops[1]), 64'd3);

    // zero-length packet, re-request waits behind source 2
    do_reset();
    push_pkt(1, 0); push_pkt(1, 0); push_pkt(2, 1);
    repeat (20) step(1'b1);
    chk("t3_ngrants", 64'(grants.size()), 64'd3);
    if (grants.size() == 3) begin
      chk("t3_g0", 64'(grants[0]), 64'd1);
      chk("t3_g1", 64'(grants[1]), 64'd2);
      chk("t3_g2", 64'(grants[2]), 64'd1);
    end
    chk("t3_pops1", 64'(pops[1]), 64'd2);
    chk("t3_pops2", 64'(pops[2]), 64'd2);
    if (done_cyc.size() > 0 && pop_cyc.size() > 0)
      chk("t3_done_lat", 64'(done_cyc[0] - pop_cyc[0]), 64'd2);
    else
      chk("t3_done_seen", 64'(done_cyc.size()), 64'd1);

    // source 3 starves mid-packet while source 0 waits
    do_reset();
    push_pkt(3, 5);
    b = 0;
    while (pops[3] < 3 && b < 30) begin step(1'b1); b++; end
    chk("t4_reach3", 64'(pops[3]), 64'd3);
    hold[3] = 1'b1;
    push_pkt(0, 1);
    d0 = pops[0]; d3 = pops[3];
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk("t4_hold_rempty", 64'(dst_rempty), 64'd1);
      chk("t4_hold_gid", 64'(grant_id), 64'd3);
      chk("t4_hold_gv", 64'(grant_valid), 64'd1);
    end
    chk("t4_no_pop0", 64'(pops[0] - d0), 64'd0);
    chk("t4_no_pop3", 64'(pops[3] - d3), 64'd0);
    hold[3] = 1'b0;
    repeat (16) step(1'b1);
    chk("t4_pops3", 64'(pops[3]), 64'd6);
    chk("t4_pops0", 64'(pops[0]), 64'd2);
    if (grants.size() == 2) chk("t4_g1", 64'(grants[1]), 64'd0);
    else chk("t4_ngrants", 64'(grants.size()), 64'd2);

    // reset in the middle of a len 5 body
    do_reset();
    push_pkt(2, 5);
    b = 0;
    while (pops[2] < 3 && b < 30) begin step(1'b1); b++; end
    chk("t6_reach", 64'(pops[2]), 64'd3);
    do_reset();
    push_pkt(1, 0); push_pkt(0, 0);
    repeat (12) step(1'b1);
    chk("t6_ngrants", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      chk("t6_g0", 64'(grants[0]), 64'd0);
      chk("t6_g1", 64'(grants[1]), 64'd1);
    end

    // randomized traffic
    do_reset();
    words_pushed = 0;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) begin
        int s;
        s = $urandom_range(0, N - 1);
        if (fq[s].size() < 16) push_pkt(s, $urandom_range(0, 6));
      end
      for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 3) != 0);
    end
    hold = '0;
    repeat (400) step(1'b1);
    tp = 0;
    for (int i = 0; i < N; i++) tp += pops[i];
    chk("rand_all_popped", 64'(tp), 64'(words_pushed));
    chk("rand_idle_end", 64'(grant_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
